// File: rtl/input_conditioner.sv
// Switch input conditioner: polarity fix, synchroniser and counter debounce
// per channel, with registered level, rise/fall pulses and a reset copy.
module input_conditioner #(
   parameter int              N_CH            = 4,
   parameter int              SYNC_STAGES     = 2,
   parameter int              DEBOUNCE_CYCLES = 16,
   parameter logic [N_CH-1:0] ACTIVE_LOW      = '0
) (
   input  logic            clock,
   input  logic            reset_i,
   input  logic [N_CH-1:0] raw_i,
   output logic            reset_o,
   output logic [N_CH-1:0] level_o,
   output logic [N_CH-1:0] rise_o,
   output logic [N_CH-1:0] fall_o,
   output logic            any_change_o
);

   localparam int CW =
      (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

   logic [N_CH-1:0] pol;
   logic [N_CH-1:0] sync_q [SYNC_STAGES];
   logic [N_CH-1:0] s;
   logic [CW-1:0]   cnt [N_CH];
   logic [N_CH-1:0] diff;
   logic [N_CH-1:0] full;
   logic [N_CH-1:0] accept;

   assign pol = raw_i ^ ACTIVE_LOW;
   assign s   = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clock) begin
      reset_o <= reset_i;
   end

   always_ff @(posedge clock) begin
      if (reset_i) begin
         for (int k = 0; k < SYNC_STAGES; k++)
            sync_q[k] <= '0;
      end else begin
         sync_q[0] <= pol;
         for (int k = 1; k < SYNC_STAGES; k++)
            sync_q[k] <= sync_q[k-1];
      end
   end

   // A channel is accepted when it has differed for the full window.
   always_comb begin
      full = '0;
      for (int i = 0; i < N_CH; i++)
         full[i] = (cnt[i] == CMAX);
   end

   assign diff   = s ^ level_o;
   assign accept = diff & full;

   always_ff @(posedge clock) begin
      if (reset_i) begin
         level_o      <= '0;
         rise_o       <= '0;
         fall_o       <= '0;
         any_change_o <= 1'b0;
         for (int i = 0; i < N_CH; i++)
            cnt[i] <= '0;
      end else begin
         level_o      <= level_o ^ accept;
         rise_o       <= accept & s;
         fall_o       <= accept & ~s;
         any_change_o <= |accept;
         for (int i = 0; i < N_CH; i++) begin
            if (diff[i] && !full[i])
               cnt[i] <= cnt[i] + CW'(1);
            else
               cnt[i] <= '0;
         end
      end
   end

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner: stimulus pushes expected
// pulse events, per-instance monitors pop and compare on any_change_o.
module tb_input_conditioner;

   typedef struct packed {
      int         cyc;
      logic [3:0] rise;
      logic [3:0] fall;
      logic [3:0] lvl;
   } exp_t;

   logic       clock = 1'b0;
   logic       reset_i;
   logic [3:0] raw_a, raw_b;
   logic       rst_a, rst_b;
   logic [3:0] level_a, rise_a, fall_a;
   logic [3:0] level_b, rise_b, fall_b;
   logic       any_a, any_b;

   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   exp_t qa[$];
   exp_t qb[$];

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   input_conditioner #(
      .N_CH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
      .ACTIVE_LOW(4'b0000)
   ) u_a (
      .clock(clock), .reset_i(reset_i), .raw_i(raw_a),
      .reset_o(rst_a), .level_o(level_a), .rise_o(rise_a),
      .fall_o(fall_a), .any_change_o(any_a)
   );

   input_conditioner #(
      .N_CH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
      .ACTIVE_LOW(4'b1000)
   ) u_b (
      .clock(clock), .reset_i(reset_i), .raw_i(raw_b),
      .reset_o(rst_b), .level_o(level_b), .rise_o(rise_b),
      .fall_o(fall_b), .any_change_o(any_b)
   );

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d",
                  name, act, exp, cyc);
      end
   endtask

   task automatic wait_n(int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic push_a(int dly, logic [3:0] r, logic [3:0] f,
                         logic [3:0] l);
      exp_t e;
      e.cyc = cyc + dly; e.rise = r; e.fall = f; e.lvl = l;
      qa.push_back(e);
   endtask

   task automatic push_b(int dly, logic [3:0] r, logic [3:0] f,
                         logic [3:0] l);
      exp_t e;
      e.cyc = cyc + dly; e.rise = r; e.fall = f; e.lvl = l;
      qb.push_back(e);
   endtask

   always @(negedge clock) begin : mon_a
      exp_t e;
      if (cyc > 0) begin
         chk("a_any_or", 32'(any_a), 32'(|(rise_a | fall_a)));
         chk("a_excl", 32'(rise_a & fall_a), 32'd0);
         if (any_a) begin
            if (qa.size() == 0) begin
               chk("a_unexpected_pulse", 32'(any_a), 32'd0);
            end else begin
               e = qa.pop_front();
               chk("a_pulse_cycle", 32'(cyc), 32'(e.cyc));
               chk("a_rise", 32'(rise_a), 32'(e.rise));
               chk("a_fall", 32'(fall_a), 32'(e.fall));
               chk("a_level", 32'(level_a), 32'(e.lvl));
            end
         end
      end
   end

   always @(negedge clock) begin : mon_b
      exp_t e;
      if (cyc > 0) begin
         chk("b_any_or", 32'(any_b), 32'(|(rise_b | fall_b)));
         chk("b_excl", 32'(rise_b & fall_b), 32'd0);
         if (any_b) begin
            if (qb.size() == 0) begin
               chk("b_unexpected_pulse", 32'(any_b), 32'd0);
            end else begin
               e = qb.pop_front();
               chk("b_pulse_cycle", 32'(cyc), 32'(e.cyc));
               chk("b_rise", 32'(rise_b), 32'(e.rise));
               chk("b_fall", 32'(fall_b), 32'(e.fall));
               chk("b_level", 32'(level_b), 32'(e.lvl));
            end
         end
      end
   end

   initial begin
      reset_i = 1'b1;
      raw_a   = 4'hF;
      raw_b   = 4'b1000;
      wait_n(1);
      for (int k = 0; k < 3; k++) begin
         chk("rst_reset_o", 32'(rst_a), 32'd1);
         chk("rst_level", 32'(level_a), 32'd0);
         chk("rst_rise", 32'(rise_a), 32'd0);
         chk("rst_fall", 32'(fall_a), 32'd0);
         chk("rst_any", 32'(any_a), 32'd0);
         chk("rst_level_b", 32'(level_b), 32'd0);
         if (k < 2) wait_n(1);
      end
      reset_i = 1'b0;
      raw_a   = 4'h0;
      wait_n(1);
      chk("rst_release_reset_o", 32'(rst_a), 32'd0);
      wait_n(4);

      // clean step up and down on channel 0
      raw_a = 4'b0001;
      push_a(6, 4'b0001, 4'b0000, 4'b0001);
      wait_n(10);
      chk("step_level_hi", 32'(level_a), 32'b0001);
      raw_a = 4'b0000;
      push_a(6, 4'b0000, 4'b0001, 4'b0000);
      wait_n(10);
      chk("step_level_lo", 32'(level_a), 32'd0);

      // 3-cycle glitch rejected, 4-cycle pulse accepted
      raw_a = 4'b0010;
      wait_n(3);
      raw_a = 4'b0000;
      wait_n(10);
      chk("glitch_level", 32'(level_a), 32'd0);
      raw_a = 4'b0010;
      push_a(6, 4'b0010, 4'b0000, 4'b0010);
      wait_n(4);
      raw_a = 4'b0000;
      push_a(6, 4'b0000, 4'b0010, 4'b0000);
      wait_n(10);
      chk("glitch_after", 32'(level_a), 32'd0);

      // simultaneous channels
      raw_a = 4'b1110;
      push_a(6, 4'b1110, 4'b0000, 4'b1110);
      wait_n(10);
      chk("simul_level", 32'(level_a), 32'b1110);
      raw_a = 4'b0000;
      push_a(6, 4'b0000, 4'b1110, 4'b0000);
      wait_n(10);

      // reset while channel 2 is mid-count
      raw_a = 4'b0100;
      wait_n(4);
      reset_i = 1'b1;
      wait_n(1);
      chk("mid_reset_o", 32'(rst_a), 32'd1);
      chk("mid_level", 32'(level_a), 32'd0);
      reset_i = 1'b0;
      push_a(6, 4'b0100, 4'b0000, 4'b0100);
      wait_n(5);
      chk("mid_level_early", 32'(level_a), 32'd0);
      wait_n(5);
      chk("mid_level_hi", 32'(level_a), 32'b0100);
      raw_a = 4'b0000;
      push_a(6, 4'b0000, 4'b0100, 4'b0000);
      wait_n(10);

      // active-low channel 3 on instance b
      chk("pol_idle_level", 32'(level_b), 32'd0);
      raw_b = 4'b0000;
      push_b(6, 4'b1000, 4'b0000, 4'b1000);
      wait_n(10);
      chk("pol_level", 32'(level_b), 32'b1000);

      wait_n(2);
      chk("qa_drained", 32'(qa.size()), 32'd0);
      chk("qb_drained", 32'(qb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
